// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory port between the I-cache fill path and the D-cache fill/writeback path.
// One transaction at a time, round-robin on ties, address/data latched at grant.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [31:0]           i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [31:0]           d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [31:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_I    = 2'd1,
        SERVE_D_RD = 2'd2,
        SERVE_D_WR = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   i_req;
    logic   d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // D wins a tie unless it was granted last; a simultaneous D read+write is a write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || last_grant == GRANT_I)) begin
                    state_next = d_write ? SERVE_D_WR : SERVE_D_RD;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
            end
            default: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_I;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                case (state_next)
                    SERVE_I: begin
                        pmem_address <= i_address;
                        last_grant   <= GRANT_I;
                    end
                    SERVE_D_RD: begin
                        pmem_address <= d_address;
                        last_grant   <= GRANT_D;
                    end
                    SERVE_D_WR: begin
                        pmem_address <= d_address;
                        pmem_wdata   <= d_wdata;
                        last_grant   <= GRANT_D;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Strobes come from the state register so a dropped request cannot abort memory.
    assign pmem_read  = (state == SERVE_I) || (state == SERVE_D_RD);
    assign pmem_write = (state == SERVE_D_WR);

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = ((state == SERVE_D_RD) || (state == SERVE_D_WR)) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: table of single transactions plus hand-written corner sequences,
// with a response scoreboard fed at grant time and drained when a requester response appears.
module tb_cache_mem_arbiter;

    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [31:0]   i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int total;
    int bad;

    cache_mem_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        logic          side_d;
        logic [LW-1:0] rdata;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic          ir, dr, dw;
        logic [31:0]   ia, da;
        logic [LW-1:0] wd;
        int            dly;
        logic          exp_d, exp_wr;
        logic [31:0]   exp_addr;
        logic [LW-1:0] exp_wdata;
        logic [LW-1:0] rd;
    } rec_t;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every requester response must match the oldest granted transaction.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_resp || d_resp) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp actual i_resp=%0b d_resp=%0b required none", i_resp, d_resp);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_i", {255'd0, i_resp}, {255'd0, ~e.side_d});
                    chk("resp_d", {255'd0, d_resp}, {255'd0, e.side_d});
                    chk("rdata_i", i_rdata, e.side_d ? '0 : e.rdata);
                    chk("rdata_d", d_rdata, e.side_d ? e.rdata : '0);
                end
            end else begin
                chk("rdata_i_quiet", i_rdata, '0);
                chk("rdata_d_quiet", d_rdata, '0);
            end
        end
    end

    task automatic drop_all();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Entered #1 after an edge with the arbiter idle; leaves #1 after the edge following the response.
    task automatic run_txn(input rec_t r);
        i_read    = r.ir;
        d_read    = r.dr;
        d_write   = r.dw;
        i_address = r.ia;
        d_address = r.da;
        d_wdata   = r.wd;
        @(posedge clk); #1;
        chk("grant_read", {255'd0, pmem_read}, {255'd0, ~r.exp_wr});
        chk("grant_write", {255'd0, pmem_write}, {255'd0, r.exp_wr});
        chk("grant_addr", {224'd0, pmem_address}, {224'd0, r.exp_addr});
        chk("grant_wdata", pmem_wdata, r.exp_wdata);
        q.push_back('{r.exp_d, r.rd});
        i_address = 32'hDEAD_BEEF;
        d_address = 32'hFEED_F00D;
        d_wdata   = ~r.wd;
        for (int k = 0; k < r.dly; k++) begin
            @(posedge clk); #1;
            chk("hold_strobe", {254'd0, pmem_read, pmem_write}, {254'd0, ~r.exp_wr, r.exp_wr});
            chk("hold_addr", {224'd0, pmem_address}, {224'd0, r.exp_addr});
            chk("hold_wdata", pmem_wdata, r.exp_wdata);
        end
        pmem_rdata = r.rd;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        drop_all();
        chk("strobe_drop", {254'd0, pmem_read, pmem_write}, '0);
    endtask

    task automatic wait_strobe(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout actual=none required=strobe within 6 cycles");
        end
    endtask

    rec_t tbl[7];

    initial begin
        logic [LW-1:0] w1, w2, w3, pa5;
        logic          ok;
        logic          exp_d;
        total = 0;
        bad   = 0;
        w1  = {8{32'h1111_2222}};
        w2  = {8{32'h3C3C_5A5A}};
        w3  = {8{32'h0BAD_CAFE}};
        pa5 = {32{8'hA5}};

        //       ir    dr    dw    ia          da          wd  dly exp_d exp_wr exp_addr    exp_wdata rd
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0,     '0, 5, 1'b0, 1'b0, 32'h0000_0060, '0, pa5};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_1000, w1, 0, 1'b1, 1'b1, 32'h0000_1000, w1, {8{32'h1234_5678}}};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300, w3, 2, 1'b0, 1'b0, 32'h0000_0200, w1, {8{32'h0F0F_0F0F}}};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0440, w2, 1, 1'b1, 1'b1, 32'h0000_0440, w2, {8{32'h7777_0000}}};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0500, w3, 3, 1'b1, 1'b0, 32'h0000_0500, w2, {8{32'hABCD_EF01}}};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0640, 32'h0000_0700, w3, 1, 1'b0, 1'b0, 32'h0000_0640, w2, {8{32'h5555_AAAA}}};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0780, w3, 0, 1'b1, 1'b0, 32'h0000_0780, w2, {8{32'h9999_1234}}};

        // Reset with every input high
        rst        = 1'b1;
        i_read     = 1'b1;
        d_read     = 1'b1;
        d_write    = 1'b1;
        i_address  = '1;
        d_address  = '1;
        d_wdata    = '1;
        pmem_rdata = '1;
        pmem_resp  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pmem_read", {255'd0, pmem_read}, '0);
        chk("rst_pmem_write", {255'd0, pmem_write}, '0);
        chk("rst_i_resp", {255'd0, i_resp}, '0);
        chk("rst_d_resp", {255'd0, d_resp}, '0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        chk("rst_addr", {224'd0, pmem_address}, '0);
        chk("rst_wdata", pmem_wdata, '0);
        rst       = 1'b0;
        pmem_resp = 1'b0;
        drop_all();

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
        end

        // Simultaneous requests right after reset: D first, then I two cycles after D's response
        do_reset();
        i_read    = 1'b1;
        d_write   = 1'b1;
        i_address = 32'h0000_0060;
        d_address = 32'h0000_1000;
        d_wdata   = w3;
        @(posedge clk); #1;
        chk("sim_d_write", {255'd0, pmem_write}, {255'd0, 1'b1});
        chk("sim_d_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_1000});
        q.push_back('{1'b1, w1});
        @(posedge clk); #1;
        pmem_rdata = w1;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        chk("sim_bubble", {254'd0, pmem_read, pmem_write}, '0);
        @(posedge clk); #1;
        chk("sim_i_read", {255'd0, pmem_read}, {255'd0, 1'b1});
        chk("sim_i_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_0060});
        q.push_back('{1'b0, pa5});
        pmem_rdata = pa5;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        drop_all();

        // Continuous contention: grants alternate D, I, D, I, D, I
        do_reset();
        i_read    = 1'b1;
        d_write   = 1'b1;
        i_address = 32'h0000_0900;
        d_address = 32'h0000_0A00;
        d_wdata   = w2;
        for (int k = 0; k < 6; k++) begin
            wait_strobe(ok);
            if (!ok) break;
            exp_d = (k % 2 == 0);
            chk("contend_side", {255'd0, pmem_write}, {255'd0, exp_d});
            chk("contend_addr", {224'd0, pmem_address}, {224'd0, exp_d ? 32'h0000_0A00 : 32'h0000_0900});
            pmem_rdata = {8{k[31:0] + 32'h0100_0000}};
            q.push_back('{exp_d, pmem_rdata});
            pmem_resp = 1'b1;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end
        drop_all();
        @(posedge clk); #1;
        q.delete();
        @(posedge clk); #1;

        // Mid-transaction reset abandons the transaction; a late response is ignored
        i_read    = 1'b1;
        i_address = 32'h0000_0080;
        @(posedge clk); #1;
        chk("mid_serve_read", {255'd0, pmem_read}, {255'd0, 1'b1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        i_read = 1'b0;
        chk("mid_rst_strobes", {254'd0, pmem_read, pmem_write}, '0);
        chk("mid_rst_addr", {224'd0, pmem_address}, '0);
        repeat (2) @(posedge clk);
        #1;
        pmem_rdata = w3;
        pmem_resp  = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_i_resp", {255'd0, i_resp}, '0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("mid_rst_still_idle", {254'd0, pmem_read, pmem_write}, '0);

        // Stray response while idle
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("stray_i_resp", {255'd0, i_resp}, '0);
        chk("stray_d_resp", {255'd0, d_resp}, '0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("stray_no_state", {254'd0, pmem_read, pmem_write}, '0);

        // Request dropped mid-serve still completes
        i_read    = 1'b1;
        i_address = 32'h0000_00C0;
        @(posedge clk); #1;
        chk("drop_grant", {255'd0, pmem_read}, {255'd0, 1'b1});
        i_read = 1'b0;
        q.push_back('{1'b0, w2});
        repeat (2) begin
            @(posedge clk); #1;
            chk("drop_hold", {255'd0, pmem_read}, {255'd0, 1'b1});
        end
        pmem_rdata = w2;
        pmem_resp  = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        chk("drop_done", {254'd0, pmem_read, pmem_write}, '0);

        @(posedge clk); #1;
        chk("scoreboard_empty", LW'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path (which refills the line the fetch stage's PC reads from) and the data-cache miss/writeback path. It serves one transaction at a time and uses round-robin priority when both requesters are pending. It latches address and write data at grant, so the memory sees stable values for the whole transaction. It routes the memory response back to the granted requester only.

## Interface
- LINE_WIDTH, 256: cache line width in bits; sets the width of every data bus.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line-fill request; held until `i_resp`.
- i_address  in  32  I-cache line address.
- i_rdata  out  LINE_WIDTH  fill data; valid only while `i_resp` = 1.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line-fill request.
- d_write  in  1  D-cache writeback request.
- d_address  in  32  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback data.
- d_rdata  out  LINE_WIDTH  fill data; valid only while `d_resp` = 1.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  memory read strobe; held for the whole transaction.
- pmem_write  out  1  memory write strobe; held for the whole transaction.
- pmem_address  out  32  latched transaction address.
- pmem_wdata  out  LINE_WIDTH  latched writeback data.
- pmem_rdata  in  LINE_WIDTH  memory read data; valid with `pmem_resp`.
- pmem_resp  in  1  memory completion pulse.

## Operation

**States**
- IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.

**Request flags**
- `i_req = i_read`.
- `d_req = d_read | d_write`.
- If `d_read` and `d_write` are both 1, the write wins.

**Grant in IDLE**
- Only `i_req`: go to SERVE_I.
- Only `d_req`: go to SERVE_D_RD or SERVE_D_WR.
- Both: grant the requester not recorded in `last_grant`.
- `last_grant` resets to I, so the D side wins the first tie.
- `last_grant` updates on every grant.

**Latching at grant**
- `pmem_address` latches from the granted requester's address.
- `pmem_wdata` latches from `d_wdata` on a D write grant.
- `pmem_wdata` holds its previous value on read grants.

**Serve states**
- SERVE_I and SERVE_D_RD drive `pmem_read` = 1; SERVE_D_WR drives `pmem_write` = 1.
- The strobe is decoded from the state register, not from requester inputs.
- On `pmem_resp`, the granted requester's `_resp` is 1 in the same cycle (combinational).
- In that same cycle, its `_rdata` equals `pmem_rdata`.
- The next state is IDLE.

**Non-granted side**
- `_resp` = 0.
- `_rdata` = 0, never a passthrough.

**Boundary conditions**
- Requester drops its request mid-serve: keep serving until `pmem_resp`, because memory cannot abort. The response is still pulsed.
- `pmem_resp` in IDLE: ignored; no `_resp` pulse and no state change.
- Request appears during another's serve: waits with no loss and is considered in the next IDLE.
- Reset asserted mid-transaction: the next state is IDLE, `last_grant` = I, and strobes drop at once. The outstanding memory transaction is abandoned. Any later `pmem_resp` is ignored per the IDLE rule.
- Starvation: with both requesters continuously asserting, grants strictly alternate I/D.

## Timing
- Reset values: every output is 0 (strobes, resps, `pmem_address`, `pmem_wdata`, rdata buses); state = IDLE.
- Request visible in IDLE at cycle N: the serve state is entered and the memory strobe is 1 at cycle N+1.
- `pmem_resp` at cycle M: requester `_resp` is 1 at cycle M; the arbiter is in IDLE at M+1; the strobe is 0 at M+1.
- Requesters drop the request at M+1, after seeing `_resp`.
- The IDLE cycle at M+1 is mandatory, so a stale request is never re-granted.
- Back-to-back transactions: the next strobe rises at M+2 at the earliest.
- Arbiter overhead: 1 cycle before the strobe, plus 1 bubble between transactions.
- `pmem_address` and `pmem_wdata` are stable from the first strobe cycle to the response cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all inputs 1 -> every output is 0, then state = IDLE.
- **I-only read:** `i_read`=1, `i_address`=0x0000_0060; memory responds after 5 cycles with `pmem_rdata`=0xA5…A5 -> `pmem_read`=1 from cycle 1 and `pmem_address`=0x60. `i_resp` pulses once with `i_rdata`=0xA5…A5, `d_resp` stays 0, and the strobe drops the next cycle.
- **Simultaneous requests after reset:** `i_read` and `d_write` both 1, `d_address`=0x0000_1000 -> D is served first (`pmem_write`=1, address 0x1000). I is served next, with `pmem_read` rising 2 cycles after the D response.
- **Continuous contention:** both requesters re-request immediately for 6 transactions -> grant order is D, I, D, I, D, I.
- **Mid-transaction reset:** assert `rst` during SERVE_I, then pulse `pmem_resp` 3 cycles later -> strobes are 0 the cycle after reset, and no `i_resp` pulse occurs.
- **Stray responses:** (a) `pmem_resp` pulsed while IDLE -> no `_resp` pulse. (b) `i_read` dropped mid-serve -> `i_resp` still pulses on `pmem_resp`.
